// File: rtl/lsu_mem_if_pkg.sv
// ============================================================================
// Module      : lsu_mem_if_pkg
// Description : Shared funct3 codes, access-size decode and alignment helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lsu_mem_if_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // funct3[1:0] == 2'b11 is treated as a word access.
    function automatic size_e op_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (op_size(funct3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_if_store_align.sv
// ============================================================================
// Module      : lsu_mem_if_store_align
// Description : Byte enables and lane-replicated store data for one access.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_if_store_align
    import lsu_mem_if_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic        is_store_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    // Loads read the full word; extension downstream picks the lanes.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = '0;
        if (is_store_i) begin
            case (op_size(funct3_i))
                SZ_BYTE: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                SZ_HALF: begin
                    be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o = {2{wdata_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = wdata_i;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_if.sv
// ============================================================================
// Module      : lsu_mem_if
// Description : Load/store memory stage with req/gnt + rvalid handshake and timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lsu_mem_if
    import lsu_mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_is_store_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [31:0]           ex_wdata_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic                  wb_valid_o,
    output logic [31:0]           wb_rdata_o,
    output logic [1:0]            wb_addr_lo_o,
    output logic [2:0]            wb_funct3_o,
    output logic                  wb_is_store_o,
    output logic                  exc_misaligned_o,
    output logic                  exc_bus_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [1:0]              op_addr_lo_q;
    logic [2:0]              op_funct3_q;
    logic                    op_is_store_q;

    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_we_q;
    logic [3:0]              mem_be_q;
    logic [31:0]             mem_wdata_q;

    logic [31:0]             wb_rdata_q, wb_rdata_d;
    logic [1:0]              wb_addr_lo_q, wb_addr_lo_d;
    logic [2:0]              wb_funct3_q, wb_funct3_d;
    logic                    wb_is_store_q, wb_is_store_d;
    logic                    exc_mis_q, exc_mis_d;
    logic                    exc_bus_q, exc_bus_d;

    logic                    accept;
    logic                    ex_misaligned;
    logic                    finish;
    logic                    finish_bus;
    logic [3:0]              align_be;
    logic [31:0]             align_wdata;

    assign accept        = (state_q == S_IDLE) && ex_valid_i;
    assign ex_misaligned = is_misaligned(ex_funct3_i, ex_addr_i[1:0]);

    lsu_mem_if_store_align u_store_align (
        .funct3_i   (ex_funct3_i),
        .addr_lo_i  (ex_addr_i[1:0]),
        .wdata_i    (ex_wdata_i),
        .is_store_i (ex_is_store_i),
        .be_o       (align_be),
        .wdata_o    (align_wdata)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        finish        = 1'b0;
        finish_bus    = 1'b0;
        wb_rdata_d    = wb_rdata_q;
        wb_addr_lo_d  = wb_addr_lo_q;
        wb_funct3_d   = wb_funct3_q;
        wb_is_store_d = wb_is_store_q;
        exc_mis_d     = exc_mis_q;
        exc_bus_d     = exc_bus_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid_i) begin
                    if (ex_misaligned) begin
                        // Fault reported straight from the execute inputs; memory untouched.
                        state_d       = S_DONE;
                        wb_rdata_d    = '0;
                        wb_addr_lo_d  = ex_addr_i[1:0];
                        wb_funct3_d   = ex_funct3_i;
                        wb_is_store_d = ex_is_store_i;
                        exc_mis_d     = 1'b1;
                        exc_bus_d     = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_gnt_i) begin
                    if (mem_rvalid_i) begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = S_DONE;
                    finish     = 1'b1;
                    finish_bus = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            wb_rdata_d    = (!finish_bus && !op_is_store_q) ? mem_rdata_i : 32'h0;
            wb_addr_lo_d  = op_addr_lo_q;
            wb_funct3_d   = op_funct3_q;
            wb_is_store_d = op_is_store_q;
            exc_mis_d     = 1'b0;
            exc_bus_d     = finish_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_addr_lo_q  <= '0;
            op_funct3_q   <= '0;
            op_is_store_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            wb_rdata_q    <= '0;
            wb_addr_lo_q  <= '0;
            wb_funct3_q   <= '0;
            wb_is_store_q <= 1'b0;
            exc_mis_q     <= 1'b0;
            exc_bus_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_addr_lo_q  <= wb_addr_lo_d;
            wb_funct3_q   <= wb_funct3_d;
            wb_is_store_q <= wb_is_store_d;
            exc_mis_q     <= exc_mis_d;
            exc_bus_q     <= exc_bus_d;
            if (accept) begin
                op_addr_lo_q  <= ex_addr_i[1:0];
                op_funct3_q   <= ex_funct3_i;
                op_is_store_q <= ex_is_store_i;
                mem_addr_q    <= {ex_addr_i[ADDR_WIDTH-1:2], 2'b00};
                mem_we_q      <= ex_is_store_i;
                mem_be_q      <= align_be;
                mem_wdata_q   <= align_wdata;
            end
        end
    end

    assign ex_ready_o       = (state_q == S_IDLE);
    assign mem_req_o        = (state_q == S_ISSUE);
    assign wb_valid_o       = (state_q == S_DONE);
    assign mem_addr_o       = mem_addr_q;
    assign mem_we_o         = mem_we_q;
    assign mem_be_o         = mem_be_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign wb_rdata_o       = wb_rdata_q;
    assign wb_addr_lo_o     = wb_addr_lo_q;
    assign wb_funct3_o      = wb_funct3_q;
    assign wb_is_store_o    = wb_is_store_q;
    assign exc_misaligned_o = exc_mis_q;
    assign exc_bus_o        = exc_bus_q;

endmodule

`default_nettype wire

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store memory interface stage between execute and the load sign/zero-extension stage.
- Accepts one load or store per transaction from execute and checks alignment.
- Generates word-aligned address, byte enables and lane-replicated store data.
- Runs a req/gnt + rvalid handshake with data memory, bounded by a response timeout; hands the raw 32-bit word plus addr[1:0] and funct3 downstream for extension.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- TIMEOUT, 255: maximum cycles in WAIT before a bus error; must be ≥1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents a memory op.
- ex_ready  out  1  block accepts an op this cycle.
- ex_is_store  in  1  1 = store, 0 = load.
- ex_funct3  in  3  RISC-V load/store funct3.
- ex_addr  in  ADDR_WIDTH  byte address.
- ex_wdata  in  32  store data in low lanes.
- mem_req  out  1  memory request.
- mem_gnt  in  1  request accepted.
- mem_addr  out  ADDR_WIDTH  word address, low two bits 0.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_rvalid  in  1  response/ack valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle completion pulse.
- wb_rdata  out  32  raw read word; 0 for stores and exceptions.
- wb_addr_lo  out  2  latched ex_addr[1:0].
- wb_funct3  out  3  latched funct3.
- wb_is_store  out  1  latched op type.
- exc_misaligned  out  1  qualified by wb_valid.
- exc_bus  out  1  timeout; qualified by wb_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, all registered outputs 0. ex_ready=1 after reset because it decodes IDLE. mem_req drops immediately; any in-flight op is abandoned with no wb_valid.
- FSM states: IDLE, ISSUE, WAIT, DONE. ex_ready = (state==IDLE).
- IDLE:
  - On ex_valid, latch addr, funct3, is_store and wdata.
  - Size is funct3[1:0]: 00 byte, 01 half, 10/11 word.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Misaligned → DONE with exc_misaligned=1; no memory access.
  - Otherwise → ISSUE.
- ISSUE:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are registered and stable until gnt.
  - mem_gnt & mem_rvalid in the same cycle → capture and go to DONE.
  - mem_gnt alone → WAIT, counter cleared.
  - No timeout while in ISSUE.
- WAIT:
  - mem_req=0; counter increments each cycle.
  - On mem_rvalid → capture mem_rdata (loads only) and go to DONE.
  - Counter reaching TIMEOUT without rvalid → DONE with exc_bus=1. rvalid on the same cycle wins, so no error.
- DONE: wb_valid=1 for exactly one cycle, then IDLE. wb_* fields hold their values until the next DONE.
- Byte enables and store data:
  - Stores: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}. SH be=4'b0011<<{addr[1],1'b0}, wdata={2{wdata[15:0]}}. SW be=4'b1111, wdata unchanged.
  - Loads: be=4'b1111, mem_we=0, mem_wdata=0.
- Latency: best case accept → wb_valid is 2 cycles (gnt+rvalid in ISSUE); misaligned case is 1 cycle.
- Throughput: one op in flight; no new accept before returning to IDLE.
- Unsolicited mem_rvalid in IDLE, ISSUE-without-gnt or DONE is ignored.

Decomposition:
- Shared header (Opcode.vh): FNC_LB/LH/LW/LBU/LHU and FNC_SB/SH/SW constants.
- FSM state encodings stay local parameters.
- One natural sub-module: store_align, combinational (funct3, addr_lo, wdata, is_store) → (be, wdata_aligned).
- Timeout counter width is $clog2(TIMEOUT+1).

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, gnt on the first ISSUE cycle, rvalid 2 cycles later → mem_addr=0x1000, be=1000, mem_wdata=0xA5A5A5A5, we=1; wb_valid 1 cycle, wb_is_store=1, wb_rdata=0.
- LH, addr=0x2002, gnt+rvalid same cycle, rdata=0x8001_1234 → wb_valid 2 cycles after accept, wb_rdata=0x80011234, wb_addr_lo=2, wb_funct3=3'b001.
- LW, addr=0x3001 → no mem_req, wb_valid next cycle with exc_misaligned=1; ex_ready high again the following cycle.
- LW, addr=0x4000, gnt after 3 stalled cycles, no rvalid, TIMEOUT=4 → mem_req stable for all 3 stall cycles; exc_bus=1 with wb_valid after 4 WAIT cycles.
- rst_n pulsed low during WAIT of an LBU → mem_req=0, ex_ready=1, no wb_valid; a later rvalid is ignored; the next op completes normally.
- Back-to-back SW 0x10 then LW 0x10 with ex_valid held → second op accepted only in the cycle after the first wb_valid; be=1111 for both.
